// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the fixed-point seven-segment display:
// digit codes, active-low segment patterns, FSM states and BCD sizing.
package seven_seg_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t DIG_DASH  = 4'd10;
  localparam digit_t DIG_BLANK = 4'd11;

  // Active-low, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    CONV_WHOLE,
    CONV_FRAC,
    PACK
  } state_e;

  // ceil(bits * log10(2)) in integer arithmetic.
  function automatic int bcd_digits(input int bits);
    return (bits * 30103 + 99999) / 100000;
  endfunction

  function automatic logic [6:0] seg_encode(input digit_t d);
    case (d)
      4'd0:     return SEG_0;
      4'd1:     return SEG_1;
      4'd2:     return SEG_2;
      4'd3:     return SEG_3;
      4'd4:     return SEG_4;
      4'd5:     return SEG_5;
      4'd6:     return SEG_6;
      4'd7:     return SEG_7;
      4'd8:     return SEG_8;
      4'd9:     return SEG_9;
      DIG_DASH: return SEG_DASH;
      default:  return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seven_segment_fixed_display_seq_bin2bcd.sv
// Sequential double-dabble: start performs the first add-3/shift step, then one
// step per cycle; done is high whenever no iterations remain.
module seq_bin2bcd
  import seven_seg_pkg::*;
#(
  parameter int IN_W   = 7,
  parameter int DIGITS = bcd_digits(IN_W),
  parameter int NB_W   = $clog2(IN_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  input  logic [NB_W-1:0]       nbits,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SR_W = 4 * DIGITS + IN_W;

  logic [SR_W-1:0] sr_q, sr_d;
  logic [NB_W-1:0] cnt_q, cnt_d;

  function automatic logic [SR_W-1:0] dabble(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int d = 0; d < DIGITS; d++) begin
      if (t[IN_W+4*d +: 4] >= 4'd5) t[IN_W+4*d +: 4] = t[IN_W+4*d +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (start) begin
      sr_d  = dabble({{(4 * DIGITS){1'b0}}, bin});
      cnt_d = nbits - NB_W'(1);
    end else if (cnt_q != '0) begin
      sr_d  = dabble(sr_q);
      cnt_d = cnt_q - NB_W'(1);
    end
  end

  // NOTE: state is only ever written here with <=; next-state math stays blocking in always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);
  assign bcd  = sr_q[SR_W-1 -: 4*DIGITS];

endmodule

// File: rtl/seven_segment_fixed_display.sv
// Signed fixed-point display: converts whole and fraction parts to BCD with one
// shared converter, packs a digit buffer and scans it onto common-anode digits.
module seven_segment_fixed_display
  import seven_seg_pkg::*;
#(
  parameter int WHOLE_W     = 7,
  parameter int FRAC_W      = 7,
  parameter int NUM_DIGITS  = 4,
  parameter int FRAC_DIGITS = 2,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clock_100Mhz,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WHOLE_W-1:0]    whole_number,
  input  logic [FRAC_W-1:0]     fraction_number,
  input  logic                  sign,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            segment,
  output logic                  dp
);

  localparam int CONV_W = (WHOLE_W > FRAC_W) ? WHOLE_W : FRAC_W;
  localparam int CONV_D = bcd_digits(CONV_W);
  localparam int NB_W   = $clog2(CONV_W + 1);
  localparam int WD     = bcd_digits(WHOLE_W);
  localparam int PAD_W  = 4 * (CONV_D + NUM_DIGITS);
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [31:0] FRAC_LIMIT = 32'(10 ** FRAC_DIGITS);

  state_e              state_q, state_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic                sign_q, sign_d;
  logic [4*WD-1:0]     whole_bcd_q, whole_bcd_d;
  logic                busy_q, busy_d, ovf_q, ovf_d, point_q, point_d;
  digit_t              buf_q [NUM_DIGITS];
  digit_t              buf_d [NUM_DIGITS];
  digit_t              pack_buf [NUM_DIGITS];
  logic                pack_ovf, minus;
  int                  sig;
  logic [PAD_W-1:0]    whole_pad, frac_pad;

  logic                conv_start, conv_done;
  logic [CONV_W-1:0]   conv_bin;
  logic [NB_W-1:0]     conv_nbits;
  logic [4*CONV_D-1:0] conv_bcd;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  seq_bin2bcd #(.IN_W(CONV_W), .DIGITS(CONV_D), .NB_W(NB_W)) u_bin2bcd (
    .clk   (clock_100Mhz),
    .rst   (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .nbits (conv_nbits),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Packing reads the fraction BCD straight off the idle converter during PACK.
  always_comb begin
    whole_pad = PAD_W'(whole_bcd_q);
    frac_pad  = PAD_W'(conv_bcd);
    sig = 1;
    for (int k = 1; k < WD; k++) begin
      if (whole_bcd_q[4*k +: 4] != 4'd0) sig = k + 1;
    end
    minus    = sign_q && ((whole_bcd_q != '0) || (frac_q != '0));
    pack_ovf = (sig + (minus ? 1 : 0) > NUM_DIGITS - FRAC_DIGITS) ||
               (32'(frac_q) >= FRAC_LIMIT);
    for (int i = 0; i < NUM_DIGITS; i++) pack_buf[i] = DIG_BLANK;
    for (int i = 0; i < FRAC_DIGITS; i++) pack_buf[i] = frac_pad[4*i +: 4];
    for (int k = 0; k < NUM_DIGITS - FRAC_DIGITS; k++) begin
      if (k < sig)                pack_buf[FRAC_DIGITS+k] = whole_pad[4*k +: 4];
      else if (minus && k == sig) pack_buf[FRAC_DIGITS+k] = DIG_DASH;
    end
    if (pack_ovf) begin
      for (int i = 0; i < NUM_DIGITS; i++) pack_buf[i] = DIG_DASH;
    end
  end

  always_comb begin
    state_d     = state_q;
    frac_d      = frac_q;
    sign_d      = sign_q;
    whole_bcd_d = whole_bcd_q;
    busy_d      = busy_q;
    ovf_d       = ovf_q;
    point_d     = point_q;
    buf_d       = buf_q;
    conv_start  = 1'b0;
    conv_bin    = CONV_W'(whole_number) << (CONV_W - WHOLE_W);
    conv_nbits  = NB_W'(WHOLE_W);
    case (state_q)
      IDLE: if (load) begin
        frac_d     = fraction_number;
        sign_d     = sign;
        conv_start = 1'b1;
        busy_d     = 1'b1;
        state_d    = CONV_WHOLE;
      end
      CONV_WHOLE: if (conv_done) begin
        whole_bcd_d = conv_bcd[4*WD-1:0];
        conv_start  = 1'b1;
        conv_bin    = CONV_W'(frac_q) << (CONV_W - FRAC_W);
        conv_nbits  = NB_W'(FRAC_W);
        state_d     = CONV_FRAC;
      end
      CONV_FRAC: if (conv_done) state_d = PACK;
      PACK: begin
        buf_d   = pack_buf;
        ovf_d   = pack_ovf;
        point_d = !pack_ovf;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan path is free-running and only reads the committed buffer, so a
  // conversion in flight never tears the display.
  always_comb begin
    cnt_d = (cnt_q == CNT_W'(REFRESH_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1))
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    anode_d = ~(NUM_DIGITS'(1) << idx_q);
    seg_d   = seg_encode(buf_q[idx_q]);
    dp_d    = !(point_q && (idx_q == IDX_W'(FRAC_DIGITS)));
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      frac_q      <= '0;
      sign_q      <= 1'b0;
      whole_bcd_q <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
      point_q     <= 1'b0;
      // NOTE: the digit buffer is a handful of plain flops, not a RAM, so it takes the reset and comes up blank.
      for (int i = 0; i < NUM_DIGITS; i++) buf_q[i] <= DIG_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      anode_q     <= '1;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      frac_q      <= frac_d;
      sign_q      <= sign_d;
      whole_bcd_q <= whole_bcd_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
      point_q     <= point_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign anode    = anode_q;
  assign segment  = seg_q;
  assign dp       = dp_q;

endmodule
